// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit
// Iterative RV32M/RV64M multiply/divide execute unit, generalised over XLEN.
// Multiplies use XLEN-step shift-add; divides use XLEN-step restoring division.
// Divide-by-zero and signed overflow are resolved without iterating.
//
// Optional build macro: RV32M_FAST_MUL_EN
//   defined   -> multiplies finish with a single-cycle 2*XLEN multiply
//   undefined -> multiplies use the XLEN-cycle shift-add path
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             abort in-flight op, drop any pending result
//   req_valid/ready   request handshake (req_ready high only in IDLE)
//   req_funct3        000 mul,001 mulh,010 mulhsu,011 mulhu,100 div,101 divu,110 rem,111 remu
//   req_a, req_b      rs1 / rs2 operands
//   req_tag           destination register tag
//   resp_valid/ready  response handshake
//   resp_data         result
//   resp_tag          tag of the completed request
//   busy              high in CALC or DONE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once resp_valid is high, resp_data/resp_tag stay constant until
// that transfer (or a flush/reset) takes place.
module rv32m_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        funct3_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              sign_a;
  logic              sign_b;
  logic              special_q;
  // Shared work register: {upper product / partial remainder, multiplier / quotient}
  logic [2*XLEN-1:0] acc;

  // Request-side operand conditioning
  logic            a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic            is_div, div_zero, div_ovf;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default: ;
    endcase
    neg_a    = a_signed & req_a[XLEN-1];
    neg_b    = b_signed & req_b[XLEN-1];
    a_abs    = neg_a ? -req_a : req_a;
    b_abs    = neg_b ? -req_b : req_b;
    is_div   = req_funct3[2];
    div_zero = is_div && (req_b == '0);
    div_ovf  = is_div && !req_funct3[0] && (req_a == MIN_VAL) && (req_b == '1);
    // funct3[1] selects rem/remu within the divide group
    if (div_zero) special_res = req_funct3[1] ? req_a : '1;
    else          special_res = req_funct3[1] ? '0 : req_a;
  end

  // One shift-add multiply step: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole register right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  // One restoring-division step: shift in the next dividend bit and subtract
  // the divisor; a borrow (MSB set) means the trial subtraction is undone.
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (div_diff[XLEN]) div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
  end

  // Final sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo_fix;
      default:                result = rem_fix;
    endcase
  end

`ifdef RV32M_FAST_MUL_EN
  logic [2*XLEN-1:0] a_wide, b_wide, fast_prod;
  always_comb begin
    a_wide    = {{XLEN{1'b0}}, a_mag};
    b_wide    = {{XLEN{1'b0}}, b_mag};
    fast_prod = a_wide * b_wide;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      funct3_q   <= '0;
      tag_q      <= '0;
      a_mag      <= '0;
      b_mag      <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      special_q  <= 1'b0;
      acc        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= CALC;
            cnt       <= '0;
            funct3_q  <= req_funct3;
            tag_q     <= req_tag;
            a_mag     <= a_abs;
            b_mag     <= b_abs;
            sign_a    <= neg_a;
            sign_b    <= neg_b;
            special_q <= div_zero | div_ovf;
            // Special results park in the low half; divides start with the
            // dividend, multiplies with the multiplier, in the low half.
            if (div_zero | div_ovf) acc <= {{XLEN{1'b0}}, special_res};
            else if (is_div)        acc <= {{XLEN{1'b0}}, a_abs};
            else                    acc <= {{XLEN{1'b0}}, b_abs};
          end
        end
        CALC: begin
          // Special cases leave on the first CALC edge with the parked value.
          if (special_q || cnt == CNT_LAST) begin
            resp_data  <= special_q ? acc[XLEN-1:0] : result;
            resp_tag   <= tag_q;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
`ifdef RV32M_FAST_MUL_EN
            if (!funct3_q[2]) begin
              acc <= fast_prod;
              cnt <= CNT_LAST;
            end else begin
              acc <= div_next;
              cnt <= cnt + 1'b1;
            end
`else
            acc <= funct3_q[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Testbench for rv32m_muldiv_unit: directed test-plan cases, backpressure,
// flush and reset scenarios, then randomized operations with random
// resp_ready, all checked against a plain-arithmetic reference model.
module tb_rv32m_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  rv32m_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [XLEN+TAG_W-1:0] exp_q[$];
  int lat_q[$];

  // resp_ready driver: random when bp_rand, else follows rr_force
  logic bp_rand  = 1'b0;
  logic rr_force = 1'b1;
  always @(posedge clk) begin
    #3;
    resp_ready = bp_rand ? ($urandom_range(0, 3) != 0) : rr_force;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    p  = '0;
    case (f)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * longint'(ub));
      3'd3:       p = ua * ub;
      3'd4:       p = (b == '0) ? '1 : 64'(sa / sb);
      3'd5:       p = (b == '0) ? '1 : ua / ub;
      3'd6:       p = (b == '0) ? ua : 64'(sa % sb);
      default:    p = (b == '0) ? ua : ua % ub;
    endcase
    if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[2*XLEN-1:XLEN];
    return p[XLEN-1:0];
  endfunction

  // Edges from accept until resp_valid is visible
  function automatic int ref_latency(input logic [2:0] f,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (f[2] && (b == '0 || (!f[0] && a == MIN_VAL && b == '1))) return 1;
`ifdef RV32M_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [XLEN-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MIN_VAL;
      3:       return XLEN'($urandom_range(0, 20));
      4:       return -XLEN'($urandom_range(1, 20));
      default: return XLEN'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                       input bit expect_resp);
    int n;
    n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: req_ready stayed 0 for %0d cycles", n);
      return;
    end
    req_valid  = 1'b1;
    req_funct3 = f;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("accept_left_idle", 64'(req_ready), 64'(0));
    if (expect_resp) begin
      exp_q.push_back({tag, ref_model(f, a, b)});
      lat_q.push_back(cycle_cnt + ref_latency(f, a, b));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag_name);
    check({tag_name, "_req_ready"},  64'(req_ready),  64'(1));
    check({tag_name, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag_name, "_resp_data"},  64'(resp_data),  64'(0));
    check({tag_name, "_resp_tag"},   64'(resp_tag),   64'(0));
    check({tag_name, "_busy"},       64'(busy),       64'(0));
  endtask

  // ---------------- monitor ----------------
  logic                  prev_valid = 1'b0;
  logic [XLEN+TAG_W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (!prev_valid) begin
        if (lat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: resp_valid=1 data=%0h tag=%0h with nothing outstanding",
                   resp_data, resp_tag);
        end else begin
          check("resp_latency", 64'(cycle_cnt), 64'(lat_q.pop_front()));
        end
      end
      check("req_ready_in_done", 64'(req_ready), 64'(0));
      if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        // Compared every valid cycle, so held data/tag under backpressure is checked too
        check("resp_data", 64'(resp_data), 64'(mon_e[XLEN-1:0]));
        check("resp_tag",  64'(resp_tag),  64'(mon_e[XLEN+TAG_W-1:XLEN]));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
    prev_valid = resp_valid && !rst;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = '0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed test-plan operations
    issue(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  1'b1);
    issue(3'b001, MIN_VAL,      MIN_VAL,      5'd1,  1'b1);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  1'b1);
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  1'b1);
    issue(3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  1'b1);
    issue(3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  1'b1);
    issue(3'b101, 32'd100,      32'd7,        5'd7,  1'b1);
    issue(3'b111, 32'd100,      32'd7,        5'd8,  1'b1);
    issue(3'b101, 32'd5,        32'd0,        5'd9,  1'b1);
    issue(3'b111, 32'd5,        32'd0,        5'd10, 1'b1);
    issue(3'b100, MIN_VAL,      32'hFFFFFFFF, 5'd11, 1'b1);
    issue(3'b110, MIN_VAL,      32'hFFFFFFFF, 5'd12, 1'b1);
    issue(3'b000, 32'd0,        32'd12345,    5'd13, 1'b1);
    drain();

    // Backpressure: hold resp_ready low for 5 cycles after resp_valid
    rr_force = 1'b0;
    @(posedge clk); #1;
    issue(3'b101, 32'd1000, 32'd9, 5'd14, 1'b1);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_resp_arrived", 64'(resp_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 64'(resp_valid), 64'(1));
      check("bp_req_ready",  64'(req_ready),  64'(0));
      check("bp_busy",       64'(busy),       64'(1));
    end
    rr_force = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(resp_valid), 64'(0));
    check("bp_release_ready", 64'(req_ready),  64'(1));
    issue(3'b111, 32'd1000, 32'd9, 5'd15, 1'b1);
    drain();

    // Flush 10 cycles into a divide
    issue(3'b100, 32'd1000, 32'd3, 5'd16, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_req_ready",  64'(req_ready),  64'(1));
    check("flush_resp_valid", 64'(resp_valid), 64'(0));
    check("flush_busy",       64'(busy),       64'(0));
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_resp", 64'(resp_valid), 64'(0));

    // Flush together with a request in IDLE: not accepted
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_req_not_accepted", 64'(busy), 64'(0));

    // Reset mid-CALC
    issue(3'b110, 32'd12345, 32'd17, 5'd17, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midcalc_reset");
    repeat (40) @(posedge clk);
    #1;
    check("reset_no_resp", 64'(resp_valid), 64'(0));

    // Randomized operations with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 60; i++)
      issue(3'($urandom_range(0, 7)), rand_op(), rand_op(), TAG_W'($urandom_range(0, 31)), 1'b1);
    drain();
    bp_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_lat_queue_empty", 64'(lat_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
